// File: rtl/pacman_audio_pkg.sv
// Shared widths, stop code and sequencer state encoding for the wakka player.
package pacman_audio_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 10;
    localparam logic [DATA_W-1:0] STOP_CODE = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        COUNT
    } state_e;

endpackage

// File: rtl/pacman_wakka_player_if.sv
// Control, ROM and audio signals between game logic / ROM (master) and the player (slave).
interface pacman_wakka_player_if;
    import pacman_audio_pkg::*;

    logic              start;
    logic              loop;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              audio_out;
    logic              busy;
    logic              done;

    modport master (
        output start, loop, abort, rom_data,
        input  rom_addr, audio_out, busy, done
    );

    modport slave (
        input  start, loop, abort, rom_data,
        output rom_addr, audio_out, busy, done
    );

endinterface

// File: rtl/audio_tick_prescaler.sv
// Duration-tick generator: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module audio_tick_prescaler #(
    parameter int TICK_DIV = 1250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/pacman_wakka_player.sv
// Wakka sound-effect sequencer: walks the sample ROM and turns each entry
// into one half-period of a square wave on audio_out.
module pacman_wakka_player
    import pacman_audio_pkg::*;
#(
    parameter int TICK_DIV   = 1250,
    parameter int START_ADDR = 1,
    parameter int LAST_ADDR  = 415,
    parameter int STOP_CODE  = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    pacman_wakka_player_if.slave bus
);

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [DATA_W-1:0] STOP_V  = DATA_W'(STOP_CODE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] half_cnt_q, half_cnt_d;
    logic              audio_q, audio_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pre_clear;
    logic              pre_en;
    logic              tick;
    logic              end_seq;

    audio_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .en    (pre_en),
        .tick  (tick)
    );

    assign pre_en = (state_q == COUNT);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        half_cnt_d = half_cnt_q;
        audio_d    = audio_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pre_clear  = 1'b0;
        end_seq    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FETCH;
                    rom_addr_d = START_A;
                    audio_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                if ((bus.rom_data == STOP_V) || (bus.rom_data == '0)) begin
                    end_seq = 1'b1;
                end else begin
                    half_cnt_d = bus.rom_data;
                    pre_clear  = 1'b1;
                    state_d    = COUNT;
                end
            end
            COUNT: begin
                if (tick) begin
                    half_cnt_d = half_cnt_q - 1'b1;
                    if (half_cnt_q == DATA_W'(1)) begin
                        audio_d = ~audio_q;
                        if (rom_addr_q == LAST_A) begin
                            end_seq = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr_q + 1'b1;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // loop is only looked at here, when the sound has run out
        if (end_seq) begin
            if (bus.loop) begin
                state_d    = FETCH;
                rom_addr_d = START_A;
                audio_d    = 1'b1;
            end else begin
                state_d = IDLE;
                audio_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (bus.abort) begin
            state_d = IDLE;
            audio_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rom_addr_q <= START_A;
            half_cnt_q <= '0;
            audio_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            half_cnt_q <= half_cnt_d;
            audio_q    <= audio_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.audio_out = audio_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
